// File: rtl/alarm_annunciator.sv
// Alarm annunciator: debounces an alarm request, latches the triggering sensor zone,
// sounds a timed square-wave siren and holds a visual strobe until the operator acknowledges.
module alarm_annunciator #(
  parameter int DEBOUNCE     = 3,   // 1..15
  parameter int TONE_HALF    = 4,   // 1..255
  parameter int SIREN_CYCLES = 64   // 2..65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       alarm_in,
  input  logic [3:0] sen,
  input  logic       ack,
  output logic       siren,
  output logic       strobe,
  output logic [3:0] latched_zone,
  output logic [7:0] event_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    ALARM    = 2'd2,
    SILENCED = 2'd3
  } state_e;

  localparam logic [3:0]  DEB_LAST   = 4'(DEBOUNCE - 1);
  localparam logic [7:0]  TONE_LAST  = 8'(TONE_HALF);
  localparam logic [15:0] SIREN_LAST = 16'(SIREN_CYCLES);

  state_e      state_q;
  logic [3:0]  deb_cnt;      // consecutive alarm_in samples seen in ARMED
  logic [7:0]  tone_cnt;     // position within the current siren half-period, 1-based
  logic [15:0] alarm_timer;  // index of the current ALARM cycle, 1-based

  assign state = state_q;

  // NOTE: every register here is written with <= so all updates in one edge see the
  // pre-edge values; blocking assignments would let later statements see new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      siren        <= 1'b0;
      strobe       <= 1'b0;
      latched_zone <= 4'd0;
      event_count  <= 8'd0;
      deb_cnt      <= 4'd0;
      tone_cnt     <= 8'd0;
      alarm_timer  <= 16'd0;
    end else if (!en) begin
      // Disarm keeps the event history (zone and count) for later inspection.
      state_q     <= IDLE;
      siren       <= 1'b0;
      strobe      <= 1'b0;
      deb_cnt     <= 4'd0;
      tone_cnt    <= 8'd0;
      alarm_timer <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= ARMED;
          deb_cnt <= 4'd0;
        end

        ARMED: begin
          if (alarm_in) begin
            if (deb_cnt == DEB_LAST) begin
              state_q      <= ALARM;
              siren        <= 1'b1;
              strobe       <= 1'b1;
              deb_cnt      <= 4'd0;
              tone_cnt     <= 8'd1;
              alarm_timer  <= 16'd1;
              latched_zone <= sen;
              if (event_count != 8'hFF) event_count <= event_count + 8'd1;
            end else begin
              deb_cnt <= deb_cnt + 4'd1;
            end
          end else begin
            deb_cnt <= 4'd0;
          end
        end

        ALARM: begin
          if (ack || (alarm_timer == SIREN_LAST)) begin
            state_q     <= SILENCED;
            siren       <= 1'b0;
            tone_cnt    <= 8'd0;
            alarm_timer <= 16'd0;
          end else begin
            alarm_timer <= alarm_timer + 16'd1;
            if (tone_cnt == TONE_LAST) begin
              siren    <= ~siren;
              tone_cnt <= 8'd1;
            end else begin
              tone_cnt <= tone_cnt + 8'd1;
            end
          end
        end

        SILENCED: begin
          // A still-asserted alarm keeps the event pending even when acknowledged.
          if (ack && !alarm_in) begin
            state_q <= ARMED;
            strobe  <= 1'b0;
            deb_cnt <= 4'd0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_annunciator.sv
// Self-checking bench for alarm_annunciator: default-parameter instance driven from vector
// tables and a scoreboard queue, plus a minimum-parameter instance for boundary behaviour.
module tb_alarm_annunciator;

  localparam int TONE_HALF = 4;

  typedef struct {
    logic       rst, en, al, ack;
    logic [3:0] sen;
    logic [1:0] st;
    logic       sir, str;
    logic [3:0] zone;
    logic [7:0] cnt;
  } vec_t;

  logic       clk, rst, en, alarm_in, ack;
  logic [3:0] sen;
  logic       siren_a, strobe_a, siren_b, strobe_b;
  logic [3:0] zone_a, zone_b;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] state_a, state_b;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t exp_q[$];
  vec_t tbl_a[$];
  vec_t tbl_b[$];

  alarm_annunciator dut_a (
    .clk(clk), .rst(rst), .en(en), .alarm_in(alarm_in), .sen(sen), .ack(ack),
    .siren(siren_a), .strobe(strobe_a), .latched_zone(zone_a), .event_count(cnt_a),
    .state(state_a)
  );

  alarm_annunciator #(.DEBOUNCE(1), .TONE_HALF(1), .SIREN_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .alarm_in(alarm_in), .sen(sen), .ack(ack),
    .siren(siren_b), .strobe(strobe_b), .latched_zone(zone_b), .event_count(cnt_b),
    .state(state_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic r, input logic e, input logic a, input logic k,
                              input logic [3:0] s, input logic [1:0] st, input logic sir,
                              input logic str, input logic [3:0] z, input logic [7:0] c);
    vec_t v;
    v.rst = r; v.en = e; v.al = a; v.ack = k; v.sen = s;
    v.st = st; v.sir = sir; v.str = str; v.zone = z; v.cnt = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d siren=%b strobe=%b zone=%h cnt=%0d, want st=%0d siren=%b strobe=%b zone=%h cnt=%0d",
               name, act[15:14], act[13], act[12], act[11:8], act[7:0],
               exp[15:14], exp[13], exp[12], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic a, input logic k,
                       input logic [3:0] s);
    rst = r; en = e; alarm_in = a; ack = k; sen = s;
  endtask

  // Drive one cycle of stimulus on dut_a, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string name);
    vec_t e;
    drive(v.rst, v.en, v.al, v.ack, v.sen);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, {state_a, siren_a, strobe_a, zone_a, cnt_a},
          {e.st, e.sir, e.str, e.zone, e.cnt});
  endtask

  task automatic step_b(input logic r, input logic e, input logic a, input logic k,
                        input logic [3:0] s, input logic [15:0] exp, input string name);
    drive(r, e, a, k, s);
    @(posedge clk);
    #1;
    check(name, {state_b, siren_b, strobe_b, zone_b, cnt_b}, exp);
  endtask

  initial begin
    logic [3:0] z, zone_exp;
    logic [7:0] c_prev, c_now;
    logic       sir_e;

    // Reset, short-pulse rejection, ack ignored in ARMED, first trigger.
    tbl_a.push_back(mk(1, 1, 1, 1, 4'hF, 2'd0, 0, 0, 4'h0, 8'd0));
    tbl_a.push_back(mk(0, 1, 0, 0, 4'h0, 2'd1, 0, 0, 4'h0, 8'd0));
    tbl_a.push_back(mk(0, 1, 1, 0, 4'h0, 2'd1, 0, 0, 4'h0, 8'd0));
    tbl_a.push_back(mk(0, 1, 1, 0, 4'h0, 2'd1, 0, 0, 4'h0, 8'd0));
    tbl_a.push_back(mk(0, 1, 0, 0, 4'h0, 2'd1, 0, 0, 4'h0, 8'd0));
    tbl_a.push_back(mk(0, 1, 1, 0, 4'h0, 2'd1, 0, 0, 4'h0, 8'd0));
    tbl_a.push_back(mk(0, 1, 1, 0, 4'h0, 2'd1, 0, 0, 4'h0, 8'd0));
    tbl_a.push_back(mk(0, 1, 0, 0, 4'h0, 2'd1, 0, 0, 4'h0, 8'd0));
    tbl_a.push_back(mk(0, 1, 0, 1, 4'h0, 2'd1, 0, 0, 4'h0, 8'd0));
    tbl_a.push_back(mk(0, 1, 1, 0, 4'hA, 2'd1, 0, 0, 4'h0, 8'd0));
    tbl_a.push_back(mk(0, 1, 1, 0, 4'hA, 2'd1, 0, 0, 4'h0, 8'd0));
    tbl_a.push_back(mk(0, 1, 1, 1, 4'hA, 2'd2, 1, 1, 4'hA, 8'd1));

    // Timeout, held-alarm ack, clear, ack-silence, disarm over ack, re-arm.
    tbl_b.push_back(mk(0, 1, 1, 0, 4'h5, 2'd3, 0, 1, 4'hA, 8'd1));
    tbl_b.push_back(mk(0, 1, 1, 1, 4'h5, 2'd3, 0, 1, 4'hA, 8'd1));
    tbl_b.push_back(mk(0, 1, 0, 1, 4'h0, 2'd1, 0, 0, 4'hA, 8'd1));
    tbl_b.push_back(mk(0, 1, 1, 0, 4'h3, 2'd1, 0, 0, 4'hA, 8'd1));
    tbl_b.push_back(mk(0, 1, 1, 0, 4'h3, 2'd1, 0, 0, 4'hA, 8'd1));
    tbl_b.push_back(mk(0, 1, 1, 0, 4'h3, 2'd2, 1, 1, 4'h3, 8'd2));
    tbl_b.push_back(mk(0, 1, 1, 1, 4'h3, 2'd3, 0, 1, 4'h3, 8'd2));
    tbl_b.push_back(mk(0, 1, 1, 0, 4'h3, 2'd3, 0, 1, 4'h3, 8'd2));
    tbl_b.push_back(mk(0, 1, 0, 1, 4'h3, 2'd1, 0, 0, 4'h3, 8'd2));
    tbl_b.push_back(mk(0, 1, 1, 0, 4'h6, 2'd1, 0, 0, 4'h3, 8'd2));
    tbl_b.push_back(mk(0, 1, 1, 0, 4'h6, 2'd1, 0, 0, 4'h3, 8'd2));
    tbl_b.push_back(mk(0, 1, 1, 0, 4'h6, 2'd2, 1, 1, 4'h6, 8'd3));
    tbl_b.push_back(mk(0, 1, 0, 0, 4'h6, 2'd2, 1, 1, 4'h6, 8'd3));
    tbl_b.push_back(mk(0, 0, 1, 1, 4'h6, 2'd0, 0, 0, 4'h6, 8'd3));
    tbl_b.push_back(mk(0, 0, 1, 0, 4'h6, 2'd0, 0, 0, 4'h6, 8'd3));
    tbl_b.push_back(mk(0, 1, 1, 0, 4'h6, 2'd1, 0, 0, 4'h6, 8'd3));

    drive(1, 0, 0, 0, 4'h0);

    for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i], $sformatf("tbl_a[%0d]", i));

    // ALARM cycles 2..64 with alarm_in held and a different sen: no re-latch, no count.
    for (int k = 2; k <= 64; k++) begin
      sir_e = (((k - 1) / TONE_HALF) % 2) == 0;
      apply(mk(0, 1, 1, 0, 4'h5, 2'd2, sir_e, 1, 4'hA, 8'd1), $sformatf("alarm_cyc%0d", k));
    end

    for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i], $sformatf("tbl_b[%0d]", i));

    // Triggers 4..257: count must saturate at 255.
    zone_exp = 4'h6;
    for (int t = 4; t <= 257; t++) begin
      z      = 4'(t);
      c_prev = (t - 1 > 255) ? 8'd255 : 8'(t - 1);
      c_now  = (t > 255) ? 8'd255 : 8'(t);
      apply(mk(0, 1, 1, 0, z, 2'd1, 0, 0, zone_exp, c_prev), $sformatf("sat_deb1_%0d", t));
      apply(mk(0, 1, 1, 0, z, 2'd1, 0, 0, zone_exp, c_prev), $sformatf("sat_deb2_%0d", t));
      apply(mk(0, 1, 1, 0, z, 2'd2, 1, 1, z, c_now), $sformatf("sat_trig%0d", t));
      zone_exp = z;
      apply(mk(0, 1, 0, 1, z, 2'd3, 0, 1, z, c_now), $sformatf("sat_ack%0d", t));
      apply(mk(0, 1, 0, 1, z, 2'd1, 0, 0, z, c_now), $sformatf("sat_clear%0d", t));
    end

    // Reset mid-ALARM overriding en=0, ack and alarm_in.
    apply(mk(0, 1, 1, 0, 4'hC, 2'd1, 0, 0, zone_exp, 8'd255), "sat_pre1");
    apply(mk(0, 1, 1, 0, 4'hC, 2'd1, 0, 0, zone_exp, 8'd255), "sat_pre2");
    apply(mk(0, 1, 1, 0, 4'hC, 2'd2, 1, 1, 4'hC, 8'd255), "trig_at_sat");
    apply(mk(0, 1, 1, 0, 4'hC, 2'd2, 1, 1, 4'hC, 8'd255), "alarm_at_sat");
    apply(mk(1, 0, 1, 1, 4'hC, 2'd0, 0, 0, 4'h0, 8'd0), "rst_mid_alarm");
    apply(mk(0, 1, 0, 0, 4'h0, 2'd1, 0, 0, 4'h0, 8'd0), "rst_release");

    // Minimum-parameter instance: single-sample trigger, 1-cycle tone, 2-cycle siren.
    step_b(0, 1, 1, 0, 4'h9, {2'd2, 1'b1, 1'b1, 4'h9, 8'd1}, "b_trig_single");
    step_b(0, 1, 0, 0, 4'h0, {2'd2, 1'b0, 1'b1, 4'h9, 8'd1}, "b_tone_toggle");
    step_b(0, 1, 0, 0, 4'h0, {2'd3, 1'b0, 1'b1, 4'h9, 8'd1}, "b_timeout");
    step_b(0, 1, 0, 1, 4'h0, {2'd1, 1'b0, 1'b0, 4'h9, 8'd1}, "b_clear");
    step_b(0, 1, 1, 0, 4'h2, {2'd2, 1'b1, 1'b1, 4'h2, 8'd2}, "b_retrig");
    step_b(0, 1, 0, 1, 4'h0, {2'd3, 1'b0, 1'b1, 4'h2, 8'd2}, "b_ack");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_annunciator.md
ALARM_ANNUNCIATOR -- requirements
Module: alarm_annunciator

Interface
REQ-001 Parameter DEBOUNCE, default 3: consecutive alarm_in-high cycles required to trigger; legal range 1..15.
REQ-002 Parameter TONE_HALF, default 4: siren half-period in clk cycles; legal range 1..255.
REQ-003 Parameter SIREN_CYCLES, default 64: maximum sounding time in clk cycles before auto-silence; legal range 2..65535.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  arm switch; 1 = armed, 0 = disarmed.
REQ-007 alarm_in  input  1  alarm request from the alarm logic, level-sensitive.
REQ-008 sen  input  4  sensor vector, sampled at trigger time.
REQ-009 ack  input  1  operator acknowledge, level-sampled each cycle.
REQ-010 siren  output  1  audible drive, square wave while sounding.
REQ-011 strobe  output  1  visual indicator, high while an event is unacknowledged.
REQ-012 latched_zone  output  4  sen value captured at trigger.
REQ-013 event_count  output  8  number of triggers, saturating.
REQ-014 state  output  2  current FSM state: IDLE=0, ARMED=1, ALARM=2, SILENCED=3.
REQ-015 All outputs SHALL be registered; no combinational input-to-output path.

Function
REQ-016 FSM SHALL have exactly the four states IDLE, ARMED, ALARM and SILENCED.
REQ-017 Transition priority, highest first: rst, then en=0, then ack, then timeout, then debounce trigger.
REQ-018 In any state, en=0 SHALL force IDLE on the next edge, with siren=0, strobe=0 and the debounce and tone counters cleared.
REQ-019 Disarm via en=0 SHALL preserve latched_zone and event_count.
REQ-020 IDLE SHALL go to ARMED on the edge where en=1 is sampled; the debounce counter starts at 0.
REQ-021 ARMED debounce: counter +1 per cycle with alarm_in=1; cleared to 0 on any cycle with alarm_in=0.
REQ-022 On the DEBOUNCE-th consecutive alarm_in=1 sample in ARMED, the next state SHALL be ALARM.
REQ-023 On that same trigger edge: latched_zone <= sen as sampled on the triggering cycle, and event_count <= event_count+1, holding at 255.
REQ-024 ALARM latency: siren=1 and strobe=1 in the first cycle after the trigger edge.
REQ-025 ALARM siren: toggles every TONE_HALF cycles, giving period 2*TONE_HALF with the first high phase exactly TONE_HALF cycles.
REQ-026 ALARM timer: counts cycles spent in ALARM; when it reaches SIREN_CYCLES the state SHALL go to SILENCED, so siren is high-or-toggling for exactly SIREN_CYCLES cycles.
REQ-027 ack=1 in ALARM SHALL go to SILENCED on the next edge, taking priority over a simultaneous timeout.
REQ-028 SILENCED outputs: siren=0, strobe=1.
REQ-029 SILENCED with ack=1 and alarm_in=0 SHALL return to ARMED, strobe=0, debounce counter 0.
REQ-030 SILENCED with ack=1 and alarm_in=1 SHALL remain in SILENCED, so a held alarm cannot be cleared.
REQ-031 ack in IDLE or ARMED SHALL have no effect.
REQ-032 alarm_in in IDLE, SILENCED or ALARM SHALL NOT increment event_count or re-latch latched_zone.
REQ-033 With DEBOUNCE=1, a single alarm_in=1 sample in ARMED SHALL trigger.
REQ-034 ack is level-sampled; a one-cycle pulse SHALL suffice for every ack-driven transition.

Reset
REQ-035 When rst=1 is sampled: state=IDLE, siren=0, strobe=0, latched_zone=0, event_count=0, and all internal counters 0.
REQ-036 rst asserted mid-ALARM SHALL silence siren and strobe on the next edge.
REQ-037 rst SHALL override en, ack and alarm_in in the same cycle.
REQ-038 After rst deasserts with en=1, the block SHALL reach ARMED one edge later.

Verification
REQ-039 Defaults, en=1, alarm_in pulses high 2 cycles then low -> state stays ARMED, siren=0, event_count=0.
REQ-040 alarm_in high 3 cycles with sen=4'b1010 -> ALARM next cycle, latched_zone=1010, event_count=1, siren pattern 1111 0000 repeating.
REQ-041 Triggered, no ack -> after 64 ALARM cycles state=SILENCED, siren=0, strobe=1.
REQ-042 In ALARM, ack=1 with alarm_in=1 -> SILENCED; then ack=1 with alarm_in=0 -> ARMED, strobe=0.
REQ-043 en toggled 0 mid-ALARM -> IDLE next edge, siren=0, latched_zone and event_count unchanged; 256 triggers -> event_count holds at 255.
REQ-044 rst=1 asserted together with en=0 and ack=1 mid-ALARM -> all outputs at reset values next edge.
